// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
// Holds the FSM state encoding, bus widths, the default wait-state count,
// the latched request payload and a strobe-decoding helper.
package data_mem_responder_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned ADDR_BUS_W      = 32;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned WAIT_CYCLES_DEF = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // Request captured at acceptance and carried to the access edge
   typedef struct packed {
      logic              wr;
      logic              bad;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Exactly one of the two strobes is asserted
   function automatic logic single_strobe(input logic rd, input logic wr);
      return rd ^ wr;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage for the data memory responder.
// Synchronous write, registered read; the storage itself is never reset,
// only the read register is.
// Ports: clk, rst_n (async active-low, clears rdata only), en (access this
// edge), we (1 = write, 0 = read), idx (word index), wdata, rdata (holds the
// last read word).
module dmem_array
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage write; deliberately without reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[idx] <= wdata;
      end
   end

   // Registered read; holds its value across writes and idle cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts a single read or write strobe from the
// control unit, inserts WAIT_CYCLES wait states, performs the access, pulses
// memReady and then holds until both strobes drop so a level-held strobe is
// serviced only once.
// Ports: clk, rst_n (async active-low), rdMem/wrMem (request strobes),
// addr (byte address, word index addr[ADDR_W+1:2]), wdata, rdata (last read
// word), memReady (one-cycle completion pulse), memBusy (not idle),
// memErr (sticky error, cleared by the next accepted request).
// Optional build macro: DMEM_ADDR_CHECK_EN -- flags misaligned or
// out-of-range addresses as errors instead of silently wrapping.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rdMem,
   input  logic                  wrMem,
   input  logic [ADDR_BUS_W-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata,
   output logic                  memReady,
   output logic                  memBusy,
   output logic                  memErr
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   req_t               req_q, req_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic               ready_d;
   logic               busy_d;
   logic               err_d;
   logic               mem_en_c;
   logic               addr_bad_c;

   // Address legality for the incoming request
`ifdef DMEM_ADDR_CHECK_EN
   assign addr_bad_c = (addr[1:0] != 2'b00) ||
                       ((addr >> (ADDR_W + 2)) != '0);
`else
   assign addr_bad_c = 1'b0;
   // Byte-offset and upper bits are ignored: accesses wrap silently
   logic unused_addr_c;
   assign unused_addr_c = ^{addr[ADDR_BUS_W-1:ADDR_W+2], addr[1:0]};
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         req_q    <= '0;
         idx_q    <= '0;
         memReady <= 1'b0;
         memBusy  <= 1'b0;
         memErr   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         idx_q    <= idx_d;
         memReady <= ready_d;
         memBusy  <= busy_d;
         memErr   <= err_d;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      idx_d    = idx_q;
      ready_d  = 1'b0;
      err_d    = memErr;
      mem_en_c = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (single_strobe(rdMem, wrMem)) begin
               req_d.wr    = wrMem;
               req_d.bad   = addr_bad_c;
               req_d.wdata = wdata;
               idx_d       = addr[ADDR_W+1:2];
               cnt_d       = '0;
               err_d       = 1'b0;
               state_d     = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            end else if (rdMem && wrMem) begin
               // Conflicting strobes: flag and park without touching memory
               err_d   = 1'b1;
               state_d = HOLD;
            end
         end
         WAIT: begin
            if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ACCESS: begin
            ready_d = 1'b1;
            state_d = HOLD;
            if (req_q.bad) begin
               err_d = 1'b1;
            end else begin
               mem_en_c = 1'b1;
            end
         end
         HOLD: begin
            // Wait for both strobes to drop so a held strobe is not re-taken
            if (!rdMem && !wrMem) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (mem_en_c),
      .we    (req_q.wr),
      .idx   (idx_q),
      .wdata (req_q.wdata),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance A (WAIT_CYCLES=1) is tracked by a
// transaction-level model every cycle; instance B (WAIT_CYCLES=0) gets
// directed latency checks.
module tb_data_mem_responder;

   localparam int unsigned TB_WAIT = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdMem, wrMem;
   logic [31:0] addr, wdata, rdata;
   logic        memReady, memBusy, memErr;

   logic        b_rd, b_wr;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic        b_ready, b_busy, b_err;

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(TB_WAIT)) dut_a (
      .clk(clk), .rst_n(rst_n), .rdMem(rdMem), .wrMem(wrMem), .addr(addr),
      .wdata(wdata), .rdata(rdata), .memReady(memReady), .memBusy(memBusy),
      .memErr(memErr)
   );

   data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .rdMem(b_rd), .wrMem(b_wr), .addr(b_addr),
      .wdata(b_wdata), .rdata(b_rdata), .memReady(b_ready), .memBusy(b_busy),
      .memErr(b_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of instance A ----------------
   logic [31:0] mem_m [256];
   logic [31:0] m_rdata;
   logic        m_ready, m_busy, m_err;
   bit          pend, hold, p_wr, p_bad;
   logic [7:0]  p_idx;
   logic [31:0] p_data;
   int          cyc, done_edge;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rdata = 0; m_ready = 0; m_busy = 0; m_err = 0;
         pend = 0; hold = 0;
      end else begin
         cyc++;
         m_ready = 0;
         if (pend) begin
            if (cyc == done_edge) begin
               pend = 0; hold = 1; m_ready = 1;
               if (p_bad) m_err = 1;
               else if (p_wr) mem_m[p_idx] = p_data;
               else m_rdata = mem_m[p_idx];
            end
         end else if (hold) begin
            if (!rdMem && !wrMem) begin hold = 0; m_busy = 0; end
         end else if (rdMem && wrMem) begin
            m_err = 1; m_busy = 1; hold = 1;
         end else if (rdMem || wrMem) begin
            pend = 1; done_edge = cyc + TB_WAIT + 1; m_busy = 1; m_err = 0;
            p_wr = wrMem; p_idx = addr[9:2]; p_data = wdata;
`ifdef DMEM_ADDR_CHECK_EN
            p_bad = (addr[1:0] != 2'b00) || (addr >= 32'h400);
`else
            p_bad = 0;
`endif
         end
      end
   end

   // Per-cycle comparison of instance A against the model
   always @(negedge clk) begin
      if (check_en) begin
         chk("cyc_memReady", 32'(memReady), 32'(m_ready));
         chk("cyc_memBusy",  32'(memBusy),  32'(m_busy));
         chk("cyc_memErr",   32'(memErr),   32'(m_err));
         chk("cyc_rdata",    rdata,         m_rdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      if (sel) begin b_rd = rd; b_wr = wr; b_addr = a; b_wdata = d; end
      else     begin rdMem = rd; wrMem = wr; addr = a; wdata = d; end
   endtask

   function automatic logic get_ready(input bit sel);
      return sel ? b_ready : memReady;
   endfunction

   function automatic logic get_busy(input bit sel);
      return sel ? b_busy : memBusy;
   endfunction

   // Raise strobes for 'hold' edges starting at the acceptance edge; report
   // the edge count from acceptance to the first memReady and the pulse count
   task automatic req(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input int hold, output int lat, output int pulses);
      drive(sel, rd, wr, a, d);
      @(posedge clk); #1;
      lat = -1; pulses = 0;
      if (hold <= 1) drive(sel, 0, 0, a, d);
      for (int n = 1; n <= hold + TB_WAIT + 4; n++) begin
         @(posedge clk); #1;
         if (get_ready(sel)) begin
            pulses++;
            if (lat < 0) lat = n;
         end
         if (n >= hold - 1) drive(sel, 0, 0, a, d);
      end
      chk("busy_released", 32'(get_busy(sel)), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, pul;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata",    rdata,           32'h0);
      chk("rst_memReady", 32'(memReady),   32'h0);
      chk("rst_memBusy",  32'(memBusy),    32'h0);
      chk("rst_memErr",   32'(memErr),     32'h0);
      chk("rst_b_rdata",  b_rdata,         32'h0);
      rst_n = 1'b1;
      check_en = 1'b1;
      @(posedge clk); #1;

      // Write then read back with one wait state
      req(0, 0, 1, 32'h10, 32'hDEADBEEF, 1, lat, pul);
      chk("wr_latency", 32'(lat), 32'd2);
      chk("wr_pulses",  32'(pul), 32'd1);
      chk("wr_rdata_unchanged", rdata, 32'h0);
      req(0, 1, 0, 32'h10, 32'h0, 1, lat, pul);
      chk("rd_latency", 32'(lat), 32'd2);
      chk("rd_data",    rdata,    32'hDEADBEEF);

      // Level-held read strobe serviced exactly once
      req(0, 1, 0, 32'h10, 32'h0, 5, lat, pul);
      chk("held_pulses", 32'(pul), 32'd1);
      chk("held_data",   rdata,    32'hDEADBEEF);

      // Conflicting strobes: error, no completion, memory untouched
      req(0, 1, 1, 32'h10, 32'h0BADF00D, 1, lat, pul);
      chk("both_pulses", 32'(pul),    32'd0);
      chk("both_err",    32'(memErr), 32'd1);
      req(0, 1, 0, 32'h10, 32'h0, 1, lat, pul);
      chk("after_err_data",  rdata,        32'hDEADBEEF);
      chk("after_err_clear", 32'(memErr),  32'd0);

      // Reset during the wait state aborts the write
      req(0, 0, 1, 32'h20, 32'h0F0F0F0F, 1, lat, pul);
      drive(0, 0, 1, 32'h20, 32'h12345678);
      @(posedge clk); #1;
      chk("pre_rst_busy", 32'(memBusy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_rdata", rdata,          32'h0);
      chk("async_rst_ready", 32'(memReady),  32'h0);
      chk("async_rst_busy",  32'(memBusy),   32'h0);
      chk("async_rst_err",   32'(memErr),    32'h0);
      drive(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      req(0, 1, 0, 32'h20, 32'h0, 1, lat, pul);
      chk("rst_abort_data", rdata, 32'h0F0F0F0F);

      // Misaligned / out-of-range address handling
      req(0, 0, 1, 32'h13, 32'h55AA55AA, 1, lat, pul);
      chk("odd_latency", 32'(lat), 32'd2);
      chk("odd_pulses",  32'(pul), 32'd1);
`ifdef DMEM_ADDR_CHECK_EN
      chk("odd_err", 32'(memErr), 32'd1);
      req(0, 1, 0, 32'h10, 32'h0, 1, lat, pul);
      chk("odd_no_write", rdata, 32'hDEADBEEF);
      req(0, 0, 1, 32'h414, 32'h77, 1, lat, pul);
      chk("range_err", 32'(memErr), 32'd1);
`else
      chk("odd_err", 32'(memErr), 32'd0);
      req(0, 1, 0, 32'h10, 32'h0, 1, lat, pul);
      chk("odd_wrap_write", rdata, 32'h55AA55AA);
      req(0, 0, 1, 32'h414, 32'h77, 1, lat, pul);
      chk("range_no_err", 32'(memErr), 32'd0);
      req(0, 1, 0, 32'h14, 32'h0, 1, lat, pul);
      chk("range_wrap_write", rdata, 32'h77);
`endif

      // Zero wait states: completion one edge after acceptance
      req(1, 0, 1, 32'h0, 32'h11111111, 1, lat, pul);
      chk("b_wr0_latency", 32'(lat), 32'd1);
      req(1, 0, 1, 32'h4, 32'h22222222, 1, lat, pul);
      chk("b_wr4_latency", 32'(lat), 32'd1);
      drive(1, 1, 0, 32'h0, 32'h0);
      @(posedge clk); #1;                       // accepted
      drive(1, 0, 0, 32'h0, 32'h0);
      chk("b_rd0_ready_e0", 32'(b_ready), 32'd0);
      @(posedge clk); #1;                       // access
      chk("b_rd0_ready_e1", 32'(b_ready), 32'd1);
      chk("b_rd0_data",     b_rdata,      32'h11111111);
      @(posedge clk); #1;                       // back to idle
      chk("b_idle_busy",    32'(b_busy),  32'd0);
      chk("b_idle_ready",   32'(b_ready), 32'd0);
      drive(1, 1, 0, 32'h4, 32'h0);
      @(posedge clk); #1;                       // accepted
      drive(1, 0, 0, 32'h0, 32'h0);
      chk("b_rd4_busy",     32'(b_busy),  32'd1);
      chk("b_rd4_ready_e0", 32'(b_ready), 32'd0);
      @(posedge clk); #1;
      chk("b_rd4_ready_e1", 32'(b_ready), 32'd1);
      chk("b_rd4_data",     b_rdata,      32'h22222222);

      repeat (3) @(posedge clk);
      check_en = 1'b0;
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the word-index width; depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving the wait states inserted before each access (0-15).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rdMem  input  1  read request strobe from the control unit.
REQ-006 SHALL have port wrMem  input  1  write request strobe from the control unit.
REQ-007 SHALL have port addr  input  32  byte address; the word index is addr[ADDR_W+1:2].
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data, held until the next completed read.
REQ-010 SHALL have port memReady  output  1  one-cycle completion pulse.
REQ-011 SHALL have port memBusy  output  1  high in every state except IDLE.
REQ-012 SHALL have port memErr  output  1  sticky error flag, cleared by the next accepted request.

Function
REQ-013 SHALL implement the FSM IDLE -> WAIT -> ACCESS -> HOLD -> IDLE.
REQ-014 In IDLE, with exactly one of rdMem/wrMem high at an edge, SHALL latch addr, wdata and the direction, clear memErr, and go to WAIT, or to ACCESS when WAIT_CYCLES=0.
REQ-015 In WAIT, SHALL count WAIT_CYCLES cycles with a 4-bit counter, then go to ACCESS.
REQ-016 In ACCESS, SHALL perform the latched read or write at that edge, assert memReady for exactly one cycle, and go to HOLD.
REQ-017 Latency: a request accepted at edge E0 SHALL drive memReady high in the cycle after edge E0+WAIT_CYCLES+1.
REQ-018 In HOLD, SHALL stay while rdMem or wrMem is high, and return to IDLE only when both are low, so a level-held strobe never re-triggers.
REQ-019 rdMem and wrMem both high in IDLE SHALL set memErr and go to HOLD without any memory access and without memReady.
REQ-020 Strobes arriving while memBusy is high SHALL be ignored.
REQ-021 A write SHALL leave rdata unchanged; a read SHALL update rdata in the same cycle memReady rises.

Reset
REQ-022 rst_n low SHALL force IDLE, counter=0, rdata=0, memReady=0, memBusy=0 and memErr=0 immediately, independent of clk.
REQ-023 Reset SHALL NOT clear the storage array.
REQ-024 Reset asserted before ACCESS SHALL abort the write, leaving the array unmodified.

Configuration
REQ-025 The macro DMEM_ADDR_CHECK_EN SHALL, when defined, treat a request with addr[1:0]!=0 or any addr bit above ADDR_W+1 set as an error: set memErr, pulse memReady, perform no access, leave rdata unchanged.
REQ-026 When DMEM_ADDR_CHECK_EN is undefined, addr[1:0] and the upper address bits SHALL be ignored, with silent wrap-around, and a single-strobe request SHALL never set memErr.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE=0, WAIT=1, ACCESS=2, HOLD=3), the DATA_W=32 constant and the default WAIT_CYCLES.
REQ-028 The storage array SHALL be one sub-module, dmem_array: synchronous write, registered read, one port.

Verification
REQ-029 WAIT_CYCLES=1: wrMem with addr=0x10, wdata=0xDEADBEEF -> memReady pulses 2 cycles after acceptance; then rdMem with addr=0x10 -> rdata=0xDEADBEEF with memReady.
REQ-030 rdMem held high for 5 cycles -> exactly one memReady pulse; memBusy stays high until rdMem falls.
REQ-031 rdMem=wrMem=1 -> memErr=1, no memReady; a following read of that word returns its prior value.
REQ-032 rst_n pulsed low during WAIT of a write of 0x12345678 to 0x20 -> all outputs 0 immediately; a later read of 0x20 returns its pre-reset value.
REQ-033 With DMEM_ADDR_CHECK_EN, write to addr=0x13 -> memErr=1 and memReady pulses; without it, the same write lands at word 4.
REQ-034 WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 separated by one idle cycle -> each memReady arrives 1 cycle after acceptance.
